// File: rtl/button_counter_pkg.sv
// Shared constants, debounce FSM encoding and the BCD step helper for the
// button counter.
package button_counter_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

  localparam logic [1:0] ST_RELEASED    = 2'd0;
  localparam logic [1:0] ST_ARM_PRESS   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_ARM_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    RELEASED    = ST_RELEASED,
    ARM_PRESS   = ST_ARM_PRESS,
    HELD        = ST_HELD,
    ARM_RELEASE = ST_ARM_RELEASE
  } db_state_e;

  // One-step BCD up/down with ripple carry/borrow across the four digits.
  // A digit >= 9 rolls to 0 on up, so the result is always valid BCD.
  function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (up) begin
          if (v[i*4 +: 4] >= 4'd9) r[i*4 +: 4] = 4'd0;
          else begin
            r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
          else begin
            r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd8 : v[i*4 +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/button_counter_debounce.sv
// Two-flop synchroniser plus four-state debounce FSM for one raw button;
// emits a registered one-cycle pulse when a press is accepted.
module debounce
  import button_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk100,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  THRESH  = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1, r_sync2, r_press;
  db_state_e     r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          w_rise;

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_press <= w_rise;
    end
  end

  // The sample that leaves a stable state counts as the first of the window,
  // so the arm state needs DEBOUNCE_CYCLES-1 further matching samples.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rise      = 1'b0;
    w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
    case (r_state)
      RELEASED: if (r_sync2) begin
        w_state_nxt = ARM_PRESS;
        w_cnt_nxt   = '0;
      end
      ARM_PRESS: begin
        if (!r_sync2) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc >= THRESH) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_rise      = 1'b1;
        end else w_cnt_nxt = w_cnt_inc;
      end
      HELD: if (!r_sync2) begin
        w_state_nxt = ARM_RELEASE;
        w_cnt_nxt   = '0;
      end
      ARM_RELEASE: begin
        if (r_sync2) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc >= THRESH) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else w_cnt_nxt = w_cnt_inc;
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_press = r_press;

endmodule

// File: rtl/button_counter.sv
// Up/down press counter: two debounced buttons drive a registered 4-digit
// BCD or 16-bit hex count for the display driver.
module button_counter
  import button_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int BCD             = 1
) (
  input  logic        clk100,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        clear,
  output logic [15:0] number,
  output logic        press_up,
  output logic        press_down
);

  logic [1:0]  w_btn, w_press;
  logic [15:0] r_number, w_number_nxt;

  assign w_btn = {btn_down, btn_up};

  for (genvar g = 0; g < 2; g++) begin : g_db
    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk100 (clk100),
      .reset  (reset),
      .i_btn  (w_btn[g]),
      .o_press(w_press[g])
    );
  end

  // Count acts on the registered pulses, one cycle after they appear.
  always_comb begin
    w_number_nxt = r_number;
    if (clear) w_number_nxt = '0;
    else if (w_press[0] ^ w_press[1]) begin
      if (BCD != 0) w_number_nxt = bcd_step(r_number, w_press[0]);
      else          w_number_nxt = w_press[0] ? r_number + 16'd1 : r_number - 16'd1;
    end
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) r_number <= '0;
    else       r_number <= w_number_nxt;
  end

  assign number     = r_number;
  assign press_up   = w_press[0];
  assign press_down = w_press[1];

endmodule

// File: tb/tb_button_counter.sv
// Directed bench: a BCD and a hex counter share the buttons; expected counts
// come from a decimal/modulo model kept in the bench.
module tb_button_counter;

  logic        clk100, reset, btn_up, btn_down, clear;
  logic [15:0] number_bcd, number_hex;
  logic        pu_b, pd_b, pu_h, pd_h;

  int n_cmp, n_err;
  int n_up, n_dn, n_both;
  int bcd_m, hex_m;
  int u0, d0, b0;

  button_counter #(.DEBOUNCE_CYCLES(4), .BCD(1)) dut_bcd (
    .clk100(clk100), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .clear(clear), .number(number_bcd), .press_up(pu_b), .press_down(pd_b)
  );

  button_counter #(.DEBOUNCE_CYCLES(4), .BCD(0)) dut_hex (
    .clk100(clk100), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .clear(clear), .number(number_hex), .press_up(pu_h), .press_down(pd_h)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  initial begin
    n_up = 0; n_dn = 0; n_both = 0;
  end

  always @(negedge clk100) begin
    if (pu_b) n_up <= n_up + 1;
    if (pd_b) n_dn <= n_dn + 1;
    if (pu_b && pd_b) n_both <= n_both + 1;
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic u, input logic d);
    btn_up = u; btn_down = d;
    repeat (10) @(negedge clk100);
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (10) @(negedge clk100);
    if (u && !d) begin
      bcd_m = (bcd_m + 1) % 10000;
      hex_m = (hex_m + 1) % 65536;
    end else if (d && !u) begin
      bcd_m = (bcd_m + 9999) % 10000;
      hex_m = (hex_m + 65535) % 65536;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk100);
    clear = 1'b0;
    @(negedge clk100);
    bcd_m = 0; hex_m = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_err = 0; bcd_m = 0; hex_m = 0;
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk100);
    chk("rst_num_bcd", number_bcd, 16'h0000);
    chk("rst_num_hex", number_hex, 16'h0000);
    chk("rst_pulses", {14'd0, pu_b, pd_b}, 16'h0000);
    reset = 1'b0;
    @(negedge clk100);
    chk("post_rst_pulses", {14'd0, pu_b, pd_b}, 16'h0000);

    // clean press: pulse 6 edges after the input change, count one later
    btn_up = 1'b1;
    repeat (5) @(negedge clk100);
    chk("clean_no_early_pulse", {15'd0, pu_b}, 16'd0);
    @(negedge clk100);
    chk("clean_pulse", {15'd0, pu_b}, 16'd1);
    chk("clean_num_before", number_bcd, 16'h0000);
    @(negedge clk100);
    chk("clean_pulse_one_cycle", {15'd0, pu_b}, 16'd0);
    chk("clean_num_after", number_bcd, 16'h0001);
    repeat (3) @(negedge clk100);
    btn_up = 1'b0;
    repeat (10) @(negedge clk100);
    bcd_m = 1; hex_m = 1;
    chk("clean_no_release_pulse", 16'(n_up), 16'd1);

    // bounce then stable hold
    u0 = n_up;
    btn_up = 1'b1; @(negedge clk100);
    btn_up = 1'b0; @(negedge clk100);
    btn_up = 1'b1; @(negedge clk100);
    btn_up = 1'b0; @(negedge clk100);
    btn_up = 1'b1;
    repeat (8) @(negedge clk100);
    btn_up = 1'b0;
    repeat (10) @(negedge clk100);
    bcd_m = 2; hex_m = 2;
    chk("bounce_one_pulse", 16'(n_up - u0), 16'd1);
    chk("bounce_num", number_bcd, to_bcd(bcd_m));

    // simultaneous up and down
    u0 = n_up; d0 = n_dn; b0 = n_both;
    press(1'b1, 1'b1);
    chk("both_up_pulse", 16'(n_up - u0), 16'd1);
    chk("both_dn_pulse", 16'(n_dn - d0), 16'd1);
    chk("both_same_cycle", 16'(n_both - b0), 16'd1);
    chk("both_num_unchanged", number_bcd, 16'h0002);

    // clear sampled together with an up pulse
    btn_up = 1'b1;
    repeat (6) @(negedge clk100);
    chk("clr_pulse_present", {15'd0, pu_b}, 16'd1);
    clear = 1'b1;
    @(negedge clk100);
    clear = 1'b0;
    bcd_m = 0; hex_m = 0;
    chk("clr_beats_up_bcd", number_bcd, 16'h0000);
    chk("clr_beats_up_hex", number_hex, 16'h0000);
    repeat (4) @(negedge clk100);
    btn_up = 1'b0;
    repeat (10) @(negedge clk100);

    // wrap both directions
    press(1'b0, 1'b1);
    chk("wrap_dn_bcd", number_bcd, 16'h9999);
    chk("wrap_dn_hex", number_hex, 16'hFFFF);
    press(1'b1, 1'b0);
    chk("wrap_up_bcd", number_bcd, 16'h0000);
    chk("wrap_up_hex", number_hex, 16'h0000);
    press(1'b0, 1'b1);
    chk("wrap_dn2_bcd", number_bcd, to_bcd(bcd_m));

    // BCD carry/borrow across digits
    do_clear();
    repeat (99) press(1'b1, 1'b0);
    chk("count_99_bcd", number_bcd, 16'h0099);
    chk("count_99_hex", number_hex, 16'(hex_m));
    press(1'b1, 1'b0);
    chk("carry_0100", number_bcd, 16'h0100);
    chk("carry_hex", number_hex, 16'h0064);
    press(1'b0, 1'b1);
    chk("borrow_0099", number_bcd, 16'h0099);

    // reset during ARM_PRESS with count 0042
    do_clear();
    repeat (42) press(1'b1, 1'b0);
    chk("count_42", number_bcd, to_bcd(bcd_m));
    btn_up = 1'b1;
    repeat (4) @(negedge clk100);
    reset = 1'b1;
    #1;
    chk("rst_mid_num", number_bcd, 16'h0000);
    chk("rst_mid_pulse", {15'd0, pu_b}, 16'd0);
    repeat (2) @(negedge clk100);
    reset = 1'b0;
    @(negedge clk100);
    chk("rst_first_cycle", {15'd0, pu_b}, 16'd0);
    repeat (4) @(negedge clk100);
    chk("rst_window_not_done", {15'd0, pu_b}, 16'd0);
    @(negedge clk100);
    chk("rst_fresh_pulse", {15'd0, pu_b}, 16'd1);
    chk("rst_num_zero", number_bcd, 16'h0000);
    @(negedge clk100);
    chk("rst_num_one", number_bcd, 16'h0001);
    btn_up = 1'b0;
    repeat (10) @(negedge clk100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
